// File: rtl/perf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_pkg                                                          |
// | Brief  : Shared state encoding and read-select width helper for perf_mon.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package perf_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  // Select width covers the cycle counter (index 0) plus every event channel.
  function automatic int sel_w(input int num_ev);
    return $clog2(num_ev + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_monitor_if                                                   |
// | Brief  : Control, event and read-port bundle of the performance monitor.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface perf_monitor_if #(
  parameter int NUM_EV = 4,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = perf_pkg::sel_w(NUM_EV);

  logic              en;
  logic [NUM_EV-1:0] ev_v;
  logic              halt;
  logic              clr;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_ovf;
  logic [CNT_W-1:0]  cycle;
  logic              frozen;
  logic              timeout;

  modport master (
    output en, ev_v, halt, clr, rd_req, rd_sel,
    input  rd_valid, rd_data, rd_ovf, cycle, frozen, timeout
  );

  modport slave (
    input  en, ev_v, halt, clr, rd_req, rd_sel,
    output rd_valid, rd_data, rd_ovf, cycle, frozen, timeout
  );

endinterface
`default_nettype wire

// File: rtl/perf_counter_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_counter_cell                                                 |
// | Brief  : One counter with sticky overflow; saturating or wrapping.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] r_value;
  logic             r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      if (&r_value) begin
        r_ovf   <= 1'b1;
        r_value <= (SATURATE != 0) ? r_value : '0;
      end else begin
        r_value <= r_value + CNT_W'(1);
      end
    end
  end

  assign value = r_value;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : perf_monitor                                                      |
// | Brief  : Cycle + per-channel event counters with halt/timeout freeze.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EV   = 4,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 100000,
  parameter int SATURATE = 1
) (
  input  logic           clk,
  input  logic           reset,
  perf_monitor_if.slave  bus
);

  localparam int          SEL_W     = sel_w(NUM_EV);
  localparam logic [64:0] c_TIMEOUT = 65'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_cnt_en;
  logic             w_to_hit;
  logic [NUM_EV:0]  w_inc;
  logic [CNT_W-1:0] w_val [NUM_EV+1];
  logic [NUM_EV:0]  w_ovf;
  logic             r_timeout;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_ovf;
  logic [CNT_W-1:0] w_rd_data;
  logic             w_rd_ovf;

  assign w_cnt_en = (r_state == ST_RUN) && bus.en;
  // Widened compare so a wrapping counter at all-ones never aliases TIMEOUT.
  assign w_to_hit = (TIMEOUT != 0) && w_cnt_en &&
                    ((65'(w_val[0]) + 65'd1) == c_TIMEOUT);

  assign w_inc[0]        = w_cnt_en;
  assign w_inc[NUM_EV:1] = {NUM_EV{w_cnt_en}} & bus.ev_v;

  // Index 0 is the cycle counter, index k is event channel k-1.
  for (genvar i = 0; i <= NUM_EV; i++) begin : g_cnt
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc[i]),
      .clr   (bus.clr),
      .value (w_val[i]),
      .ovf   (w_ovf[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = ST_RUN;
    end else if ((r_state == ST_RUN) && (bus.halt || w_to_hit)) begin
      w_state_nxt = ST_FROZEN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_timeout <= 1'b0;
    else if (bus.clr)  r_timeout <= 1'b0;
    else if (w_to_hit) r_timeout <= 1'b1;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    for (int k = 0; k <= NUM_EV; k++) begin
      if (bus.rd_sel == SEL_W'(k)) begin
        w_rd_data = w_val[k];
        w_rd_ovf  = w_ovf[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_ovf   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rd_data <= w_rd_data;
        r_rd_ovf  <= w_rd_ovf;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_ovf   = r_rd_ovf;
  assign bus.cycle    = w_val[0];
  assign bus.frozen   = (r_state == ST_FROZEN);
  assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_perf_monitor                                                   |
// | Brief  : Three perf_monitor configs under shared stimulus vs. a counting model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_perf_monitor;
  import perf_pkg::*;

  localparam int NE = 4;
  localparam int SW = sel_w(NE);
  // DUT 0: 8-bit saturating, DUT 1: 8-bit wrapping, DUT 2: 32-bit with TIMEOUT=20
  localparam int c_CW  [3] = '{8, 8, 32};
  localparam int c_SAT [3] = '{1, 0, 1};
  localparam int c_TO  [3] = '{0, 0, 20};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          t_en, t_halt, t_clr, t_req;
  logic [NE-1:0] t_ev;
  logic [SW-1:0] t_sel;

  perf_monitor_if #(.NUM_EV(NE), .CNT_W(8))  if_a ();
  perf_monitor_if #(.NUM_EV(NE), .CNT_W(8))  if_b ();
  perf_monitor_if #(.NUM_EV(NE), .CNT_W(32)) if_c ();

  assign if_a.en = t_en; assign if_a.ev_v = t_ev; assign if_a.halt = t_halt;
  assign if_a.clr = t_clr; assign if_a.rd_req = t_req; assign if_a.rd_sel = t_sel;
  assign if_b.en = t_en; assign if_b.ev_v = t_ev; assign if_b.halt = t_halt;
  assign if_b.clr = t_clr; assign if_b.rd_req = t_req; assign if_b.rd_sel = t_sel;
  assign if_c.en = t_en; assign if_c.ev_v = t_ev; assign if_c.halt = t_halt;
  assign if_c.clr = t_clr; assign if_c.rd_req = t_req; assign if_c.rd_sel = t_sel;

  perf_monitor #(.NUM_EV(NE), .CNT_W(8), .TIMEOUT(0), .SATURATE(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  perf_monitor #(.NUM_EV(NE), .CNT_W(8), .TIMEOUT(0), .SATURATE(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  perf_monitor #(.NUM_EV(NE), .CNT_W(32), .TIMEOUT(20), .SATURATE(1)) u_dut_c (
    .clk(clk), .reset(reset), .bus(if_c));

  logic [63:0] o_cyc [3];
  logic [63:0] o_dat [3];
  logic        o_val [3];
  logic        o_ovf [3];
  logic        o_frz [3];
  logic        o_to  [3];

  assign o_cyc[0] = 64'(if_a.cycle);   assign o_cyc[1] = 64'(if_b.cycle);   assign o_cyc[2] = 64'(if_c.cycle);
  assign o_dat[0] = 64'(if_a.rd_data); assign o_dat[1] = 64'(if_b.rd_data); assign o_dat[2] = 64'(if_c.rd_data);
  assign o_val[0] = if_a.rd_valid;     assign o_val[1] = if_b.rd_valid;     assign o_val[2] = if_c.rd_valid;
  assign o_ovf[0] = if_a.rd_ovf;       assign o_ovf[1] = if_b.rd_ovf;       assign o_ovf[2] = if_c.rd_ovf;
  assign o_frz[0] = if_a.frozen;       assign o_frz[1] = if_b.frozen;       assign o_frz[2] = if_c.frozen;
  assign o_to[0]  = if_a.timeout;      assign o_to[1]  = if_b.timeout;      assign o_to[2]  = if_c.timeout;

  // Reference state: plain counts per DUT, index 0 = cycles, k = channel k-1
  longint unsigned m_cnt [3][NE+1];
  bit              m_ovf [3][NE+1];
  bit              m_frz [3];
  bit              m_to  [3];
  bit              e_v   [3];
  bit              e_o   [3];
  longint unsigned e_d   [3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k <= NE; k++) begin
        m_cnt[d][k] = 0;
        m_ovf[d][k] = 1'b0;
      end
      m_frz[d] = 1'b0; m_to[d] = 1'b0;
      e_v[d] = 1'b0; e_o[d] = 1'b0; e_d[d] = 0;
    end
  endtask

  task automatic bump(input int d, input int k);
    longint unsigned mx;
    mx = (64'd1 << c_CW[d]) - 64'd1;
    if (m_cnt[d][k] == mx) begin
      m_ovf[d][k] = 1'b1;
      if (c_SAT[d] == 0) m_cnt[d][k] = 0;
    end else begin
      m_cnt[d][k] = m_cnt[d][k] + 1;
    end
  endtask

  // Advance the model across one rising edge using the current driven inputs.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      e_v[d] = t_req;
      if (t_req && (t_sel <= NE)) begin
        e_d[d] = m_cnt[d][t_sel];
        e_o[d] = m_ovf[d][t_sel];
      end else begin
        e_d[d] = 0;
        e_o[d] = 1'b0;
      end
      if (t_clr) begin
        for (int k = 0; k <= NE; k++) begin
          m_cnt[d][k] = 0;
          m_ovf[d][k] = 1'b0;
        end
        m_frz[d] = 1'b0;
        m_to[d]  = 1'b0;
      end else if (!m_frz[d]) begin
        if (t_en) begin
          bump(d, 0);
          for (int k = 1; k <= NE; k++) if (t_ev[k-1]) bump(d, k);
          if (c_TO[d] != 0 && m_cnt[d][0] == longint'(c_TO[d])) begin
            m_frz[d] = 1'b1;
            m_to[d]  = 1'b1;
          end
        end
        if (t_halt) m_frz[d] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_frozen", d),  64'(o_frz[d]), 64'(m_frz[d]));
      chk($sformatf("d%0d_timeout", d), 64'(o_to[d]),  64'(m_to[d]));
      chk($sformatf("d%0d_cycle", d),   o_cyc[d],      m_cnt[d][0]);
      chk($sformatf("d%0d_rd_valid", d), 64'(o_val[d]), 64'(e_v[d]));
      if (e_v[d]) begin
        chk($sformatf("d%0d_rd_data", d), o_dat[d],      e_d[d]);
        chk($sformatf("d%0d_rd_ovf", d),  64'(o_ovf[d]), 64'(e_o[d]));
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic en, input logic [NE-1:0] ev, input logic halt,
                      input logic clr, input logic req, input logic [SW-1:0] sel);
    t_en = en; t_ev = ev; t_halt = halt; t_clr = clr; t_req = req; t_sel = sel;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  longint unsigned exp_rd36 [NE+1];

  initial begin
    reset = 1'b1;
    t_en = 0; t_ev = '0; t_halt = 0; t_clr = 0; t_req = 0; t_sel = '0;
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_d%0d_cycle", d), o_cyc[d], 64'd0);
      chk($sformatf("rst_d%0d_rd", d), {o_dat[d][61:0], o_val[d], o_ovf[d]}, 64'd0);
      chk($sformatf("rst_d%0d_flags", d), {62'd0, o_frz[d], o_to[d]}, 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Events on channels 0 and 2 for ten cycles, then a halt cycle
    for (int i = 0; i < 10; i++) step(1, 4'b0101, 0, 0, 0, '0);
    step(1, 4'b0000, 1, 0, 0, '0);
    chk("halt_frozen", 64'(o_frz[2]), 64'd1);
    exp_rd36 = '{11, 10, 0, 10, 0};
    for (int k = 0; k <= NE; k++) begin
      step(1, 4'b1111, 1, 0, 1, SW'(k));
      chk($sformatf("halt_read_sel%0d", k), o_dat[2], exp_rd36[k]);
    end
    step(1, 4'b0000, 0, 0, 1, SW'(7));
    chk("sel7_valid", 64'(o_val[2]), 64'd1);
    chk("sel7_data",  o_dat[2],      64'd0);

    // 300 events on channel 0 from a clean start
    step(1, 4'b0001, 0, 1, 0, '0);
    for (int i = 0; i < 300; i++) step(1, 4'b0001, 0, 0, 0, '0);
    step(0, 4'b0000, 0, 0, 1, SW'(1));
    chk("sat_ch0",  o_dat[0],      64'd255);
    chk("sat_ovf",  64'(o_ovf[0]), 64'd1);
    chk("wrap_ch0", o_dat[1],      64'd44);
    chk("wrap_ovf", 64'(o_ovf[1]), 64'd1);

    // Timeout at 20 counted cycles
    step(1, 4'b0000, 0, 1, 0, '0);
    for (int i = 0; i < 19; i++) step(1, 4'b0000, 0, 0, 0, '0);
    chk("to_pre_frozen", 64'(o_frz[2]), 64'd0);
    step(1, 4'b0000, 0, 0, 0, '0);
    chk("to_frozen",  64'(o_frz[2]), 64'd1);
    chk("to_timeout", 64'(o_to[2]),  64'd1);
    chk("to_cycle",   o_cyc[2],      64'd20);
    for (int i = 0; i < 5; i++) step(1, 4'b1111, 0, 0, 0, '0);
    chk("to_cycle_hold", o_cyc[2], 64'd20);

    // clr + halt + read together while frozen
    step(1, 4'b0000, 1, 1, 1, '0);
    chk("clr_rd_data", o_dat[2],      64'd20);
    chk("clr_frozen",  64'(o_frz[2]), 64'd0);
    chk("clr_cycle",   o_cyc[2],      64'd0);
    chk("clr_timeout", 64'(o_to[2]),  64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 3) != 0), NE'($urandom),
           logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 1)), SW'($urandom_range(0, 7)));
    end

    // Reset asserted in the same cycle as a read request
    step(1, 4'b0011, 0, 0, 0, '0);
    t_req = 1'b1; t_sel = '0;
    reset = 1'b1;
    #1;
    chk("async_rst_cycle", o_cyc[2], 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, 4'b0000, 0, 0, 0, '0);
    chk("rst_read_dropped", 64'(o_val[2]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter NUM_EV, default 4, number of event channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 SHALL have parameter TIMEOUT, default 100000, cycle count that forces a freeze; 0 disables.
REQ-004 SHALL have parameter SATURATE, default 1; 1 = counters saturate at all-ones, 0 = counters wrap.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port en, input, 1, global count enable.
REQ-008 SHALL have port ev_v, input, NUM_EV, per-channel event strobe (bit i = one event on channel i this cycle).
REQ-009 SHALL have port halt, input, 1, end-of-run request.
REQ-010 SHALL have port clr, input, 1, synchronous clear of all counters and flags.
REQ-011 SHALL have port rd_req, input, 1, read request.
REQ-012 SHALL have port rd_sel, input, SEL_W = clog2(NUM_EV+1), 0 = cycle counter, k = event channel k-1.
REQ-013 SHALL have port rd_valid, output, 1, read data valid.
REQ-014 SHALL have port rd_data, output, CNT_W, read value.
REQ-015 SHALL have port rd_ovf, output, 1, overflow flag of the selected counter.
REQ-016 SHALL have port cycle, output, CNT_W, live cycle counter value.
REQ-017 SHALL have port frozen, output, 1, high in FROZEN state.
REQ-018 SHALL have port timeout, output, 1, sticky: freeze was caused by TIMEOUT.

Function
REQ-019 SHALL implement two states, RUN and FROZEN; counters change only in RUN.
REQ-020 In RUN with en=1, the cycle counter SHALL increment by 1 every cycle; event counter i SHALL increment by 1 when ev_v[i]=1.
REQ-021 In RUN with en=0, all counters SHALL hold.
REQ-022 halt=1 in RUN SHALL move to FROZEN on the next edge; events and the cycle in the halt cycle SHALL still be counted.
REQ-023 When TIMEOUT!=0 and the cycle counter increments to TIMEOUT, the block SHALL enter FROZEN and set timeout on that same edge.
REQ-024 At all-ones, an increment SHALL hold the value when SATURATE=1 and wrap to 0 when SATURATE=0; in both cases the counter's sticky ovf bit SHALL set.
REQ-025 clr=1 SHALL, on the next edge, zero all counters, ovf bits and timeout, and enter RUN; clr SHALL take priority over halt, TIMEOUT and counting in the same cycle.
REQ-026 halt in FROZEN SHALL have no effect; only clr or reset leaves FROZEN.
REQ-027 Reads: rd_req sampled at edge N SHALL produce rd_valid=1 with rd_data/rd_ovf during cycle N+1 (latency 1, one beat per request); back-to-back requests SHALL be honoured every cycle.
REQ-028 Read data SHALL reflect counter values before the edge that samples rd_req (a read concurrent with clr returns pre-clear values).
REQ-029 rd_sel > NUM_EV SHALL return rd_valid=1, rd_data=0, rd_ovf=0.
REQ-030 Reads SHALL work identically in RUN and FROZEN.
REQ-031 cycle SHALL equal the internal cycle counter register with no extra latency.

Reset
REQ-032 On reset assertion, asynchronously: all counters 0, ovf bits 0, state RUN, frozen=0, timeout=0, rd_valid=0, rd_data=0, rd_ovf=0, cycle=0.
REQ-033 Reset mid-read SHALL drop the pending read; no rd_valid after deassertion without a new rd_req.

Structure
REQ-034 Package perf_pkg SHALL hold the RUN/FROZEN state enum and the SEL_W width function.
REQ-035 One sub-module, perf_counter_cell (CNT_W, SATURATE params; inc, clr inputs; value, ovf outputs), SHALL be instantiated NUM_EV+1 times (cycle counter included).

Verification
REQ-036 NUM_EV=4, en=1, ev_v=4'b0101 for 10 cycles then halt -> frozen=1 next cycle; reads return cycle=11, ch0=10, ch1=0, ch2=10, ch3=0.
REQ-037 CNT_W=8, SATURATE=1, ev_v[0]=1 for 300 cycles, TIMEOUT=0 -> ch0 reads 255, rd_ovf=1; SATURATE=0 same stimulus -> ch0 reads 44, rd_ovf=1.
REQ-038 TIMEOUT=20, en=1, no halt -> frozen=1 and timeout=1 after edge 20; cycle holds 20 thereafter.
REQ-039 clr and halt asserted together in FROZEN with rd_req, rd_sel=0 -> rd_data returns pre-clear value, next cycle state RUN, cycle=0, timeout=0.
REQ-040 rd_sel=7 with NUM_EV=4 -> rd_valid=1, rd_data=0; reset asserted same cycle as rd_req -> rd_valid stays 0.
